mii_tx_nibbler: RTL and testbench

//  MAC-side MII transmit stage. Takes a byte stream from the MAC TX datapath and drives
//  the MII TX pins: mii_txd, mii_tx_en and mii_tx_er. The passive MII monitor observes these pins.

---
 rtl/mii_tx_nibbler.sv | 273 +++++++++++++++++++++++++++
 tb/tb_mii_tx_nibbler.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mii_tx_nibbler.sv
// mii_tx_nibbler: MAC-side MII transmit stage (preamble/SFD, nibble serializer,
// short-frame pad, inter-packet gap). Define MII_TX_CRC_EN to append a CRC-32 FCS.
module mii_tx_nibbler #(
  parameter int PREAMBLE_NIBBLES = 15,
  parameter int MIN_FRAME_BYTES  = 60,
  parameter int IPG_BYTES        = 12
) (
  input  logic       mii_tx_clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_sop,
  input  logic       tx_eop,
  input  logic       tx_err,
  output logic       tx_ready,
  output logic [3:0] mii_txd,
  output logic       mii_tx_en,
  output logic       mii_tx_er,
  output logic       frame_done,
  output logic       underrun
);

  localparam int IPG_CLKS = 2 * IPG_BYTES;
  localparam int CNT_TOP  = (IPG_CLKS > PREAMBLE_NIBBLES) ? IPG_CLKS : PREAMBLE_NIBBLES;
  localparam int CW       = $clog2(CNT_TOP + 9);
  localparam int BW       = $clog2(MIN_FRAME_BYTES + 1);

  localparam logic [CW-1:0] PRE_LAST = CW'(PREAMBLE_NIBBLES);
  localparam logic [CW-1:0] IPG_LAST = CW'(IPG_CLKS - 1);
  localparam logic [BW-1:0] MIN_CNT  = BW'(MIN_FRAME_BYTES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_DATA,
    S_PAD,
`ifdef MII_TX_CRC_EN
    S_FCS,
`endif
    S_ABRT,
    S_IPG
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            phase_q, phase_d;
  logic [BW-1:0]   byte_cnt_q, byte_cnt_d;
  logic [7:0]      hold_q, hold_d;
  logic            herr_q, herr_d;
  logic            heop_q, heop_d;
  logic            tail;

  logic [3:0]      txd_q, txd_d;
  logic            en_q, en_d;
  logic            er_q, er_d;
  logic            rdy_q, rdy_d;
  logic            done_q, done_d;
  logic            unr_q, unr_d;

`ifdef MII_TX_CRC_EN
  localparam logic [CW-1:0] FCS_LAST = CW'(7);

  logic [31:0]     crc_q, crc_d;

  function automatic logic [31:0] crc_nib(input logic [31:0] c,
                                          input logic [3:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 4; i++) begin
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  // CRC follows the data/pad nibble currently on the pins, frozen during FCS
  always_comb begin
    crc_d = 32'hFFFF_FFFF;
    unique case (state_q)
      S_DATA, S_PAD: crc_d = crc_nib(crc_q, txd_q);
      S_FCS:         crc_d = crc_q;
      default:       crc_d = 32'hFFFF_FFFF;
    endcase
  end
`endif

  // Sequencing: preamble count, byte hold register, byte count, pad/gap
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    phase_d    = phase_q;
    byte_cnt_d = byte_cnt_q;
    hold_d     = hold_q;
    herr_d     = herr_q;
    heop_d     = heop_q;
    tail       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d      = '0;
        byte_cnt_d = '0;
        if (tx_valid && tx_sop) state_d = S_PRE;
      end
      S_PRE: begin
        if (cnt_q != PRE_LAST) begin
          cnt_d = cnt_q + CW'(1);
        end else if (tx_valid) begin
          state_d    = S_DATA;
          phase_d    = 1'b0;
          hold_d     = tx_data;
          herr_d     = tx_err;
          heop_d     = tx_eop;
          byte_cnt_d = BW'(1);
        end else begin
          state_d = S_ABRT;
        end
      end
      S_DATA: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else if (heop_q) begin
          tail = 1'b1;
        end else if (tx_valid && !tx_sop) begin
          phase_d = 1'b0;
          hold_d  = tx_data;
          herr_d  = tx_err;
          heop_d  = tx_eop;
          if (byte_cnt_q != MIN_CNT) byte_cnt_d = byte_cnt_q + BW'(1);
        end else begin
          state_d = S_ABRT;
        end
      end
      S_PAD: begin
        if (!phase_q) phase_d = 1'b1;
        else          tail    = 1'b1;
      end
`ifdef MII_TX_CRC_EN
      S_FCS: begin
        if (cnt_q != FCS_LAST) begin
          cnt_d = cnt_q + CW'(1);
        end else begin
          cnt_d   = '0;
          state_d = S_IPG;
        end
      end
`endif
      S_ABRT: begin
        cnt_d   = '0;
        state_d = S_IPG;
      end
      S_IPG: begin
        if (cnt_q != IPG_LAST) begin
          cnt_d = cnt_q + CW'(1);
        end else begin
          cnt_d   = '0;
          state_d = (tx_valid && tx_sop) ? S_PRE : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // a byte just finished with no more data behind it: pad or close
    if (tail) begin
      cnt_d = '0;
      if (byte_cnt_q < MIN_CNT) begin
        state_d    = S_PAD;
        phase_d    = 1'b0;
        byte_cnt_d = byte_cnt_q + BW'(1);
      end else begin
`ifdef MII_TX_CRC_EN
        state_d = S_FCS;
`else
        state_d = S_IPG;
`endif
      end
    end
  end

  // Pin values for the next clock, decoded from the next state
  always_comb begin
    txd_d  = 4'h0;
    en_d   = 1'b0;
    er_d   = 1'b0;
    rdy_d  = 1'b0;
    done_d = 1'b0;
    unr_d  = 1'b0;
    unique case (state_d)
      S_IDLE: rdy_d = 1'b1;
      S_PRE: begin
        en_d  = 1'b1;
        rdy_d = (cnt_d == PRE_LAST);
        txd_d = (cnt_d == PRE_LAST) ? 4'hD : 4'h5;
      end
      S_DATA: begin
        en_d  = 1'b1;
        txd_d = phase_d ? hold_d[7:4] : hold_d[3:0];
        er_d  = herr_d;
        rdy_d = phase_d && !heop_d;
`ifdef MII_TX_CRC_EN
        done_d = 1'b0;
`else
        done_d = phase_d && heop_d && (byte_cnt_d == MIN_CNT);
`endif
      end
      S_PAD: begin
        en_d = 1'b1;
`ifdef MII_TX_CRC_EN
        done_d = 1'b0;
`else
        done_d = phase_d && (byte_cnt_d == MIN_CNT);
`endif
      end
`ifdef MII_TX_CRC_EN
      S_FCS: begin
        en_d   = 1'b1;
        txd_d  = ~crc_d[{cnt_d[2:0], 2'b00} +: 4];
        done_d = (cnt_d == FCS_LAST);
      end
`endif
      S_ABRT: begin
        en_d  = 1'b1;
        er_d  = 1'b1;
        unr_d = 1'b1;
      end
      default: ;
    endcase
  end

  // State and output registers
  always_ff @(posedge mii_tx_clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      phase_q    <= 1'b0;
      byte_cnt_q <= '0;
      hold_q     <= 8'h00;
      herr_q     <= 1'b0;
      heop_q     <= 1'b0;
      txd_q      <= 4'h0;
      en_q       <= 1'b0;
      er_q       <= 1'b0;
      rdy_q      <= 1'b0;
      done_q     <= 1'b0;
      unr_q      <= 1'b0;
`ifdef MII_TX_CRC_EN
      crc_q      <= 32'hFFFF_FFFF;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      byte_cnt_q <= byte_cnt_d;
      hold_q     <= hold_d;
      herr_q     <= herr_d;
      heop_q     <= heop_d;
      txd_q      <= txd_d;
      en_q       <= en_d;
      er_q       <= er_d;
      rdy_q      <= rdy_d;
      done_q     <= done_d;
      unr_q      <= unr_d;
`ifdef MII_TX_CRC_EN
      crc_q      <= crc_d;
`endif
    end
  end

  // SOP is never taken in IDLE; it waits for the SFD clock
  assign tx_ready   = rdy_q & ~((state_q == S_IDLE) & tx_sop);
  assign mii_txd    = txd_q;
  assign mii_tx_en  = en_q;
  assign mii_tx_er  = er_q;
  assign frame_done = done_q;
  assign underrun   = unr_q;

endmodule

// File: tb/tb_mii_tx_nibbler.sv
// tb_mii_tx_nibbler: directed frames against mii_tx_nibbler.
// Covers preamble, nibble order, pad, underrun, tx_err, stray bytes, reset.
module tb_mii_tx_nibbler;

  localparam int MINB = 60;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid, tx_sop, tx_eop, tx_err;
  logic       tx_ready;
  logic [3:0] mii_txd;
  logic       mii_tx_en, mii_tx_er, frame_done, underrun;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  logic [3:0] rx_nib[$];
  logic       rx_er[$];
  int done_at = -1;
  int n_done = 0;
  int n_unr = 0;
  int idle_run = 0;
  int gap_before = 0;
  int rise_cyc = 0;
  int start_cyc = 0;
  logic en_prev = 1'b0;
  logic first_rdy = 1'b0;

  mii_tx_nibbler dut (
    .mii_tx_clk (clk),
    .reset      (reset),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_sop     (tx_sop),
    .tx_eop     (tx_eop),
    .tx_err     (tx_err),
    .tx_ready   (tx_ready),
    .mii_txd    (mii_txd),
    .mii_tx_en  (mii_tx_en),
    .mii_tx_er  (mii_tx_er),
    .frame_done (frame_done),
    .underrun   (underrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // pin recorder, sampled mid-cycle
  always @(negedge clk) begin
    if (mii_tx_en) begin
      if (!en_prev) begin
        gap_before = idle_run;
        rise_cyc   = cyc;
      end
      rx_nib.push_back(mii_txd);
      rx_er.push_back(mii_tx_er);
      if (frame_done) done_at = rx_nib.size() - 1;
      idle_run = 0;
    end else begin
      idle_run++;
    end
    if (frame_done) n_done++;
    if (underrun) n_unr++;
    en_prev = mii_tx_en;
  end

  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] bv(input int i);
    return 8'(8'hA7 + i * 13);
  endfunction

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  task automatic clr();
    rx_nib.delete();
    rx_er.delete();
    done_at = -1;
    n_done  = 0;
    n_unr   = 0;
  endtask

  task automatic send_frame(input int n, input int cut, input int erri,
                            input int sopi, input int rst_at);
    int i;
    int guard;
    i = 0;
    guard = 0;
    @(posedge clk); #1;
    start_cyc = cyc;
    while (i < n && i < cut && guard < 4000) begin
      tx_valid = 1'b1;
      tx_sop   = (i == 0) || (i == sopi);
      tx_eop   = (i == n - 1);
      tx_err   = (i == erri);
      tx_data  = bv(i);
      @(negedge clk);
      if (guard == 0) first_rdy = tx_ready;
      if (rst_at > 0 && rx_nib.size() >= rst_at) begin
        #2 reset = 1'b1;
        break;
      end
      if (tx_ready) i++;
      @(posedge clk); #1;
      guard++;
    end
    tx_valid = 1'b0;
    tx_sop   = 1'b0;
    tx_eop   = 1'b0;
    tx_err   = 1'b0;
    tx_data  = 8'h00;
    if (guard >= 4000) check("drv_timeout", guard, 0);
  endtask

  task automatic wait_end();
    int k;
    k = 0;
    while (k < 3000 && !(rx_nib.size() > 0 && !mii_tx_en)) begin
      @(negedge clk);
      k++;
    end
    if (k >= 3000) check("end_timeout", k, 0);
  endtask

  task automatic check_frame(input string tag, input int n, input int cut,
                             input int erri, input int sopi);
    logic [3:0] xn[$];
    logic       xe[$];
    logic       ab;
    int         nb;
    int         total;
    int         bad;
    logic [7:0] b;
    logic [31:0] c;
    for (int k = 0; k < 15; k++) begin
      xn.push_back(4'h5);
      xe.push_back(1'b0);
    end
    xn.push_back(4'hD);
    xe.push_back(1'b0);
    ab = (cut < n) || (sopi > 0 && sopi < n);
    nb = ab ? ((cut < n) ? cut : sopi) : n;
    for (int i = 0; i < nb; i++) begin
      b = bv(i);
      xn.push_back(b[3:0]);
      xe.push_back(i == erri);
      xn.push_back(b[7:4]);
      xe.push_back(i == erri);
    end
    if (ab) begin
      xn.push_back(4'h0);
      xe.push_back(1'b1);
    end else begin
      for (int i = n; i < MINB; i++) begin
        xn.push_back(4'h0);
        xe.push_back(1'b0);
        xn.push_back(4'h0);
        xe.push_back(1'b0);
      end
`ifdef MII_TX_CRC_EN
      total = (n > MINB) ? n : MINB;
      c = 32'hFFFF_FFFF;
      for (int i = 0; i < total; i++) c = crc_byte(c, (i < n) ? bv(i) : 8'h00);
      c = ~c;
      for (int k = 0; k < 8; k++) begin
        xn.push_back(c[4*k +: 4]);
        xe.push_back(1'b0);
      end
`endif
    end
    check({tag, "_len"}, rx_nib.size(), xn.size());
    bad = -1;
    for (int i = 0; i < xn.size() && i < rx_nib.size(); i++) begin
      if (rx_nib[i] !== xn[i] || rx_er[i] !== xe[i]) begin
        bad = i;
        break;
      end
    end
    check({tag, "_first_bad_nib"}, bad, -1);
    if (ab) begin
      check({tag, "_done_n"}, n_done, 0);
      check({tag, "_unr_n"}, n_unr, 1);
    end else begin
      check({tag, "_done_n"}, n_done, 1);
      check({tag, "_done_at"}, done_at, xn.size() - 1);
      check({tag, "_unr_n"}, n_unr, 0);
`ifdef MII_TX_CRC_EN
      // good-frame residue in the reflected register (0xC704DD7B bit-reversed)
      c = 32'hFFFF_FFFF;
      for (int j = 16; j + 1 < rx_nib.size(); j += 2) c = crc_byte(c, {rx_nib[j+1], rx_nib[j]});
      check({tag, "_residue"}, c, 32'hDEBB20E3);
`endif
    end
  endtask

  initial begin
    reset    = 1'b1;
    tx_valid = 1'b0;
    tx_sop   = 1'b0;
    tx_eop   = 1'b0;
    tx_err   = 1'b0;
    tx_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_en", mii_tx_en, 0);
    check("rst_er", mii_tx_er, 0);
    check("rst_txd", mii_txd, 0);
    check("rst_rdy", tx_ready, 0);
    check("rst_done", frame_done, 0);
    check("rst_unr", underrun, 0);
    @(negedge clk) reset = 1'b0;
    repeat (2) @(posedge clk);

    // 64-byte frame from idle
    clr();
    send_frame(64, 999, -1, -1, 0);
    wait_end();
    check_frame("t1", 64, 999, -1, -1);
    check("t1_start", rise_cyc - start_cyc, 1);
    check("t1_b0_lo", rx_nib[16], 4'h7);
    check("t1_b0_hi", rx_nib[17], 4'hA);
    check("t1_sop_rdy", first_rdy, 0);

    // short frame, SOP waiting through the gap
    clr();
    send_frame(10, 999, -1, -1, 0);
    wait_end();
    check_frame("t2", 10, 999, -1, -1);
    check("t2_gap", gap_before, 24);

    // underrun after byte 5 of 40
    clr();
    send_frame(40, 5, -1, -1, 0);
    wait_end();
    check_frame("t3", 40, 5, -1, -1);
    check("t3_gap", gap_before, 24);

    // tx_err on byte 3
    clr();
    send_frame(20, 999, 3, -1, 0);
    wait_end();
    check_frame("t4", 20, 999, 3, -1);
    check("t4_gap_after_unr", gap_before, 24);

    // SOP on byte 7 aborts the frame
    clr();
    send_frame(8, 999, -1, 7, 0);
    wait_end();
    check_frame("t7", 8, 999, -1, 7);

    // pad boundaries
    clr();
    send_frame(59, 999, -1, -1, 0);
    wait_end();
    check_frame("t59", 59, 999, -1, -1);
    check("t59_gap", gap_before, 24);
    clr();
    send_frame(60, 999, -1, -1, 0);
    wait_end();
    check_frame("t60", 60, 999, -1, -1);

    // stray non-SOP bytes in idle
    repeat (30) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      tx_valid = 1'b1;
      tx_sop   = 1'b0;
      tx_data  = 8'(8'h30 + k);
      @(negedge clk);
      check("t5_stray_rdy", tx_ready, 1);
      check("t5_stray_en", mii_tx_en, 0);
      @(posedge clk); #1;
    end
    tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("t5_idle_en", mii_tx_en, 0);
    clr();
    send_frame(12, 999, -1, -1, 0);
    wait_end();
    check_frame("t5", 12, 999, -1, -1);
    check("t5_start", rise_cyc - start_cyc, 1);
    check("t5_sop_rdy", first_rdy, 0);

    // reset in the middle of data
    repeat (30) @(posedge clk);
    clr();
    send_frame(64, 999, -1, -1, 40);
    #1;
    check("t6_rst_en", mii_tx_en, 0);
    check("t6_rst_er", mii_tx_er, 0);
    check("t6_rst_txd", mii_txd, 0);
    check("t6_rst_rdy", tx_ready, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    clr();
    send_frame(12, 999, -1, -1, 0);
    wait_end();
    check_frame("t6", 12, 999, -1, -1);
    check("t6_start", rise_cyc - start_cyc, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
